// File: rtl/pdm_capture_ctrl_if.sv
// PCM stream toward the consumer: buffered sample, valid flag and ready back-pressure.
interface pdm_capture_ctrl_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pdm_capture_ctrl.sv
// Sequences mic power, decimator reset and configuration for the CIC PDM decimator,
// drops post-reset settling samples and buffers valid PCM in a fall-through FIFO.
module pdm_capture_ctrl #(
  parameter int unsigned WAKE_CYCLES = 1024,
  parameter int unsigned DISCARD     = 3,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [7:0]                    cfg_alpha,
  input  logic [2:0]                    cfg_shift,
  input  logic                          cfg_update,
  output logic                          mic_en,
  output logic                          dp_rst,
  output logic [7:0]                    dp_hpf_alpha,
  output logic [2:0]                    dp_scale_shift,
  input  logic signed [15:0]            dp_pcm,
  input  logic                          dp_pcm_valid,
  pdm_capture_ctrl_if.master            stream,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    overflow_cnt,
  output logic [1:0]                    state
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned WCW = $clog2(WAKE_CYCLES + 1);
  localparam int unsigned DCW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_WAKE,
    S_SETTLE,
    S_RUN,
    S_RESTART
  } state_t;

  state_t         st, st_nxt;
  logic [WCW-1:0] wake_cnt;
  logic [DCW-1:0] disc_cnt;
  logic [7:0]     pend_alpha;
  logic [2:0]     pend_shift;
  logic           pending_flag;
  logic           push;
  logic           settle_entry;
  logic           wake_start;

  logic [15:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           full, pop, wr_en, drop;

  // Next-state and push decision; enable=0 overrides everything but a RUN-cycle sample.
  always_comb begin
    st_nxt = st;
    push   = 1'b0;
    case (st)
      S_OFF: begin
        if (enable) st_nxt = S_WAKE;
      end
      S_WAKE: begin
        if (wake_cnt == '0) st_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (dp_pcm_valid && (disc_cnt == '0)) begin
          push   = 1'b1;
          st_nxt = S_RUN;
        end
      end
      S_RUN: begin
        push = dp_pcm_valid;
        if (cfg_update || pending_flag) st_nxt = S_RESTART;
      end
      S_RESTART: begin
        st_nxt = S_SETTLE;
      end
      default: begin
        st_nxt = S_OFF;
      end
    endcase
    if (!enable) begin
      st_nxt = S_OFF;
      if (st != S_RUN) push = 1'b0;
    end
  end

  always_comb begin
    settle_entry = (st_nxt == S_SETTLE) && (st != S_SETTLE);
    wake_start   = (st == S_OFF) && (st_nxt == S_WAKE);
  end

  always_comb begin
    mic_en = (st != S_OFF);
    dp_rst = (st == S_OFF) || (st == S_WAKE) || (st == S_RESTART);
    case (st)
      S_OFF:     state = 2'd0;
      S_WAKE:    state = 2'd1;
      S_SETTLE:  state = 2'd2;
      S_RESTART: state = 2'd2;
      S_RUN:     state = 2'd3;
      default:   state = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_OFF;
    end else begin
      st <= st_nxt;
    end
  end

  // Wake and discard counters; active config is only swapped on entry to SETTLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wake_cnt       <= '0;
      disc_cnt       <= '0;
      dp_hpf_alpha   <= 8'hFF;
      dp_scale_shift <= '0;
      pend_alpha     <= 8'hFF;
      pend_shift     <= '0;
      pending_flag   <= 1'b0;
    end else begin
      if (wake_start) begin
        wake_cnt <= WCW'(WAKE_CYCLES - 1);
      end else if ((st == S_WAKE) && (wake_cnt != '0)) begin
        wake_cnt <= wake_cnt - 1'b1;
      end

      if (settle_entry) begin
        disc_cnt       <= DCW'(DISCARD);
        dp_hpf_alpha   <= pend_alpha;
        dp_scale_shift <= pend_shift;
      end else if ((st == S_SETTLE) && dp_pcm_valid && (disc_cnt != '0)) begin
        disc_cnt <= disc_cnt - 1'b1;
      end

      // A pulse coinciding with the swap stays pending for the next restart.
      if (cfg_update) begin
        pend_alpha   <= cfg_alpha;
        pend_shift   <= cfg_shift;
        pending_flag <= 1'b1;
      end else if (settle_entry) begin
        pending_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    full  = (count == (AW + 1)'(FIFO_DEPTH));
    pop   = stream.out_valid && stream.out_ready;
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wake_start) begin
        overflow_cnt <= '0;
      end else if (drop && (overflow_cnt != 8'hFF)) begin
        overflow_cnt <= overflow_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dp_pcm;
  end

  assign stream.out_valid = (count != '0);
  assign stream.out_data  = stream.out_valid ? mem[rd_ptr] : '0;
  assign fifo_level       = count;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Scenario bench for pdm_capture_ctrl with a queue-based model of the PCM buffer.
module tb_pdm_capture_ctrl;
  localparam int WC = 16;
  localparam int DC = 2;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  cfg_alpha = '0;
  logic [2:0]  cfg_shift = '0;
  logic        cfg_update = 1'b0;
  logic        mic_en, dp_rst;
  logic [7:0]  dp_hpf_alpha;
  logic [2:0]  dp_scale_shift;
  logic [15:0] dp_pcm = '0;
  logic        dp_pcm_valid = 1'b0;
  logic [2:0]  fifo_level;
  logic [7:0]  overflow_cnt;
  logic [1:0]  state;

  pdm_capture_ctrl_if stream_if ();

  pdm_capture_ctrl #(.WAKE_CYCLES(WC), .DISCARD(DC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_alpha(cfg_alpha), .cfg_shift(cfg_shift), .cfg_update(cfg_update),
    .mic_en(mic_en), .dp_rst(dp_rst),
    .dp_hpf_alpha(dp_hpf_alpha), .dp_scale_shift(dp_scale_shift),
    .dp_pcm(dp_pcm), .dp_pcm_valid(dp_pcm_valid),
    .stream(stream_if),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total = 0;
  logic [15:0] mq[$];
  int          m_ovf = 0;
  logic [7:0]  m_alpha = 8'hFF;
  logic [2:0]  m_shift = 3'd0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    dp_pcm = d;
    dp_pcm_valid = 1'b1;
    step();
    dp_pcm_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) step();
  endtask

  function automatic void model_push(input logic [15:0] d);
    if (mq.size() < FD) mq.push_back(d);
    else if (m_ovf < 255) m_ovf++;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (state !== 2'd0) $display("FAIL rst_state got=%0d exp=0", state); else passed++;
    total++; if (mic_en !== 1'b0 || dp_rst !== 1'b1) $display("FAIL rst_mic_dprst got=%b%b exp=01", mic_en, dp_rst); else passed++;
    total++; if (dp_hpf_alpha !== 8'hFF || dp_scale_shift !== 3'd0) $display("FAIL rst_cfg got=%0d/%0d exp=255/0", dp_hpf_alpha, dp_scale_shift); else passed++;
    total++; if (fifo_level !== 3'd0 || stream_if.out_valid !== 1'b0 || stream_if.out_data !== 16'h0) $display("FAIL rst_fifo got lvl=%0d v=%b d=%h exp 0/0/0", fifo_level, stream_if.out_valid, stream_if.out_data); else passed++;
    total++; if (overflow_cnt !== 8'd0) $display("FAIL rst_ovf got=%0d exp=0", overflow_cnt); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_wake();
    int n;
    enable = 1'b1;
    step();
    n = 1;
    total++; if (mic_en !== 1'b1 || state !== 2'd1 || dp_rst !== 1'b1) $display("FAIL wake_entry got mic=%b st=%0d rst=%b exp 1/1/1", mic_en, state, dp_rst); else passed++;
    m_alpha = 8'($urandom);
    m_shift = 3'($urandom);
    cfg_alpha = m_alpha;
    cfg_shift = m_shift;
    cfg_update = 1'b1;
    step();
    n++;
    cfg_update = 1'b0;
    while (dp_rst === 1'b1 && n < 64) begin
      step();
      n++;
    end
    total++; if (n != WC + 1) $display("FAIL wake_len got=%0d exp=%0d", n, WC + 1); else passed++;
    total++; if (state !== 2'd2) $display("FAIL wake_to_settle got=%0d exp=2", state); else passed++;
    total++; if (dp_hpf_alpha !== m_alpha || dp_scale_shift !== m_shift) $display("FAIL wake_cfg_apply got=%0d/%0d exp=%0d/%0d", dp_hpf_alpha, dp_scale_shift, m_alpha, m_shift); else passed++;
  endtask

  task automatic test_settle_discard();
    for (int i = 0; i < DC; i++) begin
      send(16'($urandom));
      gap();
    end
    total++; if (fifo_level !== 3'd0 || state !== 2'd2) $display("FAIL discard got lvl=%0d st=%0d exp 0/2", fifo_level, state); else passed++;
    send(16'h1234);
    model_push(16'h1234);
    total++; if (stream_if.out_valid !== 1'b1 || stream_if.out_data !== 16'h1234) $display("FAIL first_sample got v=%b d=%h exp 1/1234", stream_if.out_valid, stream_if.out_data); else passed++;
    total++; if (fifo_level !== 3'd1 || state !== 2'd3) $display("FAIL first_level got lvl=%0d st=%0d exp 1/3", fifo_level, state); else passed++;
  endtask

  task automatic test_restart();
    logic [15:0] d;
    m_alpha = 8'd200;
    m_shift = 3'd3;
    cfg_alpha = m_alpha;
    cfg_shift = m_shift;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    total++; if (dp_rst !== 1'b1 || state !== 2'd2) $display("FAIL restart_pulse got rst=%b st=%0d exp 1/2", dp_rst, state); else passed++;
    step();
    total++; if (dp_rst !== 1'b0 || dp_hpf_alpha !== 8'd200 || dp_scale_shift !== 3'd3) $display("FAIL restart_cfg got rst=%b a=%0d s=%0d exp 0/200/3", dp_rst, dp_hpf_alpha, dp_scale_shift); else passed++;
    for (int i = 0; i < DC; i++) begin
      gap();
      send(16'($urandom));
    end
    total++; if (fifo_level !== 3'(mq.size())) $display("FAIL restart_discard got lvl=%0d exp=%0d", fifo_level, mq.size()); else passed++;
    d = 16'($urandom);
    send(d);
    model_push(d);
    total++; if (fifo_level !== 3'(mq.size()) || state !== 2'd3) $display("FAIL restart_resume got lvl=%0d st=%0d exp %0d/3", fifo_level, state, mq.size()); else passed++;
  endtask

  task automatic test_drain(input string tag);
    int n;
    n = mq.size();
    stream_if.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      total++;
      if (!(stream_if.out_valid === 1'b1 && stream_if.out_data === mq[0]))
        $display("FAIL %s_order[%0d] got v=%b d=%h exp v=1 d=%h", tag, i, stream_if.out_valid, stream_if.out_data, mq[0]);
      else passed++;
      step();
      void'(mq.pop_front());
    end
    stream_if.out_ready = 1'b0;
    total++; if (fifo_level !== 3'd0 || stream_if.out_valid !== 1'b0) $display("FAIL %s_empty got lvl=%0d v=%b exp 0/0", tag, fifo_level, stream_if.out_valid); else passed++;
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      send(d);
      model_push(d);
      gap();
    end
    total++; if (fifo_level !== 3'(mq.size())) $display("FAIL ovf_level got=%0d exp=%0d", fifo_level, mq.size()); else passed++;
    total++; if (overflow_cnt !== 8'(m_ovf)) $display("FAIL ovf_count got=%0d exp=%0d", overflow_cnt, m_ovf); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] x;
    x = 16'($urandom);
    dp_pcm = x;
    dp_pcm_valid = 1'b1;
    stream_if.out_ready = 1'b1;
    step();
    dp_pcm_valid = 1'b0;
    stream_if.out_ready = 1'b0;
    void'(mq.pop_front());
    mq.push_back(x);
    total++; if (fifo_level !== 3'(mq.size()) || overflow_cnt !== 8'(m_ovf)) $display("FAIL fullpp got lvl=%0d ovf=%0d exp %0d/%0d", fifo_level, overflow_cnt, mq.size(), m_ovf); else passed++;
    total++; if (stream_if.out_data !== mq[0]) $display("FAIL fullpp_head got=%h exp=%h", stream_if.out_data, mq[0]); else passed++;
    test_drain("fullpp");
  endtask

  task automatic test_push_pop_empty();
    logic [15:0] d;
    d = 16'($urandom);
    dp_pcm = d;
    dp_pcm_valid = 1'b1;
    stream_if.out_ready = 1'b1;
    step();
    dp_pcm_valid = 1'b0;
    stream_if.out_ready = 1'b0;
    model_push(d);
    total++; if (stream_if.out_valid !== 1'b1 || fifo_level !== 3'd1 || stream_if.out_data !== d) $display("FAIL emptypp got v=%b lvl=%0d d=%h exp 1/1/%h", stream_if.out_valid, fifo_level, stream_if.out_data, d); else passed++;
    test_drain("emptypp");
  endtask

  task automatic test_disable_in_run();
    logic [15:0] d;
    d = 16'($urandom);
    enable = 1'b0;
    send(d);
    model_push(d);
    total++; if (state !== 2'd0 || mic_en !== 1'b0 || dp_rst !== 1'b1) $display("FAIL run_off got st=%0d mic=%b rst=%b exp 0/0/1", state, mic_en, dp_rst); else passed++;
    total++; if (fifo_level !== 3'(mq.size()) || stream_if.out_data !== d) $display("FAIL run_off_push got lvl=%0d d=%h exp %0d/%h", fifo_level, stream_if.out_data, mq.size(), d); else passed++;
  endtask

  task automatic test_wake_abort();
    int n;
    enable = 1'b1;
    step();
    m_ovf = 0;
    total++; if (state !== 2'd1 || overflow_cnt !== 8'(m_ovf)) $display("FAIL rewake got st=%0d ovf=%0d exp 1/0", state, overflow_cnt); else passed++;
    repeat ($urandom_range(1, WC - 4)) step();
    enable = 1'b0;
    step();
    total++; if (state !== 2'd0 || mic_en !== 1'b0 || dp_rst !== 1'b1) $display("FAIL wake_abort got st=%0d mic=%b rst=%b exp 0/0/1", state, mic_en, dp_rst); else passed++;
    enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (dp_rst === 1'b1 && n < 64);
    total++; if (n != WC + 1) $display("FAIL rewake_len got=%0d exp=%0d", n, WC + 1); else passed++;
    total++; if (fifo_level !== 3'(mq.size())) $display("FAIL fifo_survives got=%0d exp=%0d", fifo_level, mq.size()); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] d;
    for (int i = 0; i < DC; i++) begin
      send(16'($urandom));
      gap();
    end
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom);
      send(d);
      model_push(d);
      gap();
    end
    total++; if (fifo_level !== 3'd3 || state !== 2'd3 || dp_hpf_alpha !== m_alpha) $display("FAIL prerst got lvl=%0d st=%0d a=%0d exp 3/3/%0d", fifo_level, state, dp_hpf_alpha, m_alpha); else passed++;
    rst_n = 1'b0;
    step();
    mq.delete();
    m_ovf = 0;
    total++; if (fifo_level !== 3'd0 || stream_if.out_valid !== 1'b0) $display("FAIL midrst_fifo got lvl=%0d v=%b exp 0/0", fifo_level, stream_if.out_valid); else passed++;
    total++; if (dp_hpf_alpha !== 8'hFF || dp_scale_shift !== 3'd0 || state !== 2'd0) $display("FAIL midrst_ctl got a=%0d s=%0d st=%0d exp 255/0/0", dp_hpf_alpha, dp_scale_shift, state); else passed++;
    rst_n = 1'b1;
  endtask

  initial begin
    stream_if.out_ready = 1'b0;
    test_reset();
    test_wake();
    test_settle_discard();
    test_restart();
    test_drain("run");
    test_overflow();
    test_full_push_pop();
    test_push_pop_empty();
    test_disable_in_run();
    test_wake_abort();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
